// File: rtl/param_updown_counter.sv
// param_updown_counter: parametrised up/down counter with parallel load, wrap or saturate,
// tc lookahead and a registered carry/borrow pulse. Define CNT_OVF_STICKY_EN for a sticky overflow flag.
module param_updown_counter #(
    parameter int WIDTH     = 3,
    parameter int MODULUS   = 8,
    parameter int RESET_VAL = 0,
    parameter int SATURATE  = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`ifdef CNT_OVF_STICKY_EN
    input  logic             ovf_clr,
    output logic             ovf_sticky,
`endif
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             carry
);

    localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_Q   = WIDTH'(RESET_VAL);
    // One extra bit so MODULUS == 2**WIDTH is representable in the load range check.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    logic             at_max;
    logic             at_min;
    logic             load_in_range;
    logic [WIDTH-1:0] q_next;
    logic             carry_next;

    assign at_max        = (q == MAX_Q);
    assign at_min        = (q == '0);
    assign load_in_range = ({1'b0, load_val} < MOD_EXT);
    assign tc            = en & ~load & ((up_dn & at_max) | (~up_dn & at_min));

    always_comb begin
        q_next     = q;
        carry_next = 1'b0;
        if (load) begin
            q_next = load_in_range ? load_val : MAX_Q;
        end else if (en) begin
            if (up_dn) begin
                if (at_max) begin
                    carry_next = 1'b1;
                    q_next     = (SATURATE != 0) ? q : '0;
                end else begin
                    q_next = q + WIDTH'(1);
                end
            end else begin
                if (at_min) begin
                    carry_next = 1'b1;
                    q_next     = (SATURATE != 0) ? q : MAX_Q;
                end else begin
                    q_next = q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q     <= RST_Q;
            carry <= 1'b0;
        end else begin
            q     <= q_next;
            carry <= carry_next;
        end
    end

`ifdef CNT_OVF_STICKY_EN
    // A boundary crossing on the same edge as a clear keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky <= 1'b0;
        end else if (carry_next) begin
            ovf_sticky <= 1'b1;
        end else if (ovf_clr) begin
            ovf_sticky <= 1'b0;
        end
    end
`endif

endmodule
